// File: rtl/gate_pkg.sv
// Shared gate controller types: state encoding and seven-segment glyphs.
package gate_pkg;

    typedef enum logic [1:0] {
        StClosed  = 2'd0,
        StOpening = 2'd1,
        StOpen    = 2'd2,
        StClosing = 2'd3
    } gate_state_e;

    // Active-low segments, bit order gfedcba.
    localparam logic [6:0] HexClosed = 7'b0001110;
    localparam logic [6:0] HexOpen   = 7'b0001000;
    localparam logic [6:0] HexMoving = 7'b0111111;

    function automatic logic [6:0] hex_glyph(gate_state_e st);
        logic [6:0] g;
        g = HexMoving;
        if (st == StClosed) g = HexClosed;
        if (st == StOpen)   g = HexOpen;
        return g;
    endfunction

endpackage

// File: rtl/gate_plant_if.sv
// Command and status bundle between the gate plant and its operator.
interface gate_plant_if;
    logic       CMD_OPEN;
    logic       CMD_CLOSE;
    logic       OBSTRUCT;
    logic       SENSOR;
    logic       LIMIT_OPEN;
    logic       MOTOR;
    logic       DIR;
    logic [7:0] POS;
    logic [6:0] HEX0;
    logic       LEDG;
    logic       LEDR;

    modport master (
        output CMD_OPEN, CMD_CLOSE, OBSTRUCT,
        input  SENSOR, LIMIT_OPEN, MOTOR, DIR, POS, HEX0, LEDG, LEDR
    );

    modport slave (
        input  CMD_OPEN, CMD_CLOSE, OBSTRUCT,
        output SENSOR, LIMIT_OPEN, MOTOR, DIR, POS, HEX0, LEDG, LEDR
    );
endinterface

// File: rtl/tick_gen.sv
// Free-running prescaler; tick_o is high for one cycle every TICK_DIV clocks.
module tick_gen #(
    parameter int unsigned TICK_DIV = 270000
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);
    localparam int unsigned CntW = $clog2(TICK_DIV);
    localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick_o = (cnt_q == CntLast);
        cnt_d  = tick_o ? '0 : cnt_q + CntW'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/gate_plant.sv
// Motorised gate controller: command qualification, position stepping, status decode.
module gate_plant
    import gate_pkg::*;
#(
    parameter int unsigned TRAVEL_STEPS = 100,
    parameter int unsigned TICK_DIV     = 270000
) (
    input logic        CLOCK_27,
    input logic        RESET,
    gate_plant_if.slave bus
);
    localparam logic [7:0] TravelMax = 8'(TRAVEL_STEPS);

    logic        tick;
    logic        open_req, close_req;
    gate_state_e state_q, state_d;
    logic [7:0]  pos_q, pos_d;
    logic        sensor_q, limit_q, motor_q, dir_q, ledg_q, ledr_q;
    logic [6:0]  hex_q;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk_i  (CLOCK_27),
        .rst_i  (RESET),
        .tick_o (tick)
    );

    assign open_req  = bus.CMD_OPEN & ~bus.CMD_CLOSE;
    assign close_req = bus.CMD_CLOSE & ~bus.CMD_OPEN;

    // State changes always win over a coincident position step.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        unique case (state_q)
            StClosed: if (open_req) state_d = StOpening;
            StOpen:   if (close_req && !bus.OBSTRUCT) state_d = StClosing;
            StOpening: begin
                if (close_req) begin
                    state_d = StClosing;
                end else if (tick) begin
                    if (pos_q >= TravelMax - 8'd1) begin
                        pos_d   = TravelMax;
                        state_d = StOpen;
                    end else begin
                        pos_d = pos_q + 8'd1;
                    end
                end
            end
            StClosing: begin
                if (bus.OBSTRUCT || open_req) begin
                    state_d = StOpening;
                end else if (tick) begin
                    // <= 1 also covers a reversal entered at POS 0.
                    if (pos_q <= 8'd1) begin
                        pos_d   = 8'd0;
                        state_d = StClosed;
                    end else begin
                        pos_d = pos_q - 8'd1;
                    end
                end
            end
        endcase
    end

    // Outputs registered from next-state so they always equal the decode of state_q/pos_q.
    always_ff @(posedge CLOCK_27 or posedge RESET) begin
        if (RESET) begin
            state_q  <= StClosed;
            pos_q    <= 8'd0;
            sensor_q <= 1'b1;
            limit_q  <= 1'b0;
            motor_q  <= 1'b0;
            dir_q    <= 1'b0;
            ledg_q   <= 1'b0;
            ledr_q   <= 1'b0;
            hex_q    <= HexClosed;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            sensor_q <= (pos_d == 8'd0);
            limit_q  <= (pos_d == TravelMax);
            motor_q  <= (state_d == StOpening) || (state_d == StClosing);
            dir_q    <= (state_d == StOpening);
            ledg_q   <= (state_d == StOpening);
            ledr_q   <= (state_d == StClosing);
            hex_q    <= hex_glyph(state_d);
        end
    end

    assign bus.SENSOR     = sensor_q;
    assign bus.LIMIT_OPEN = limit_q;
    assign bus.MOTOR      = motor_q;
    assign bus.DIR        = dir_q;
    assign bus.POS        = pos_q;
    assign bus.HEX0       = hex_q;
    assign bus.LEDG       = ledg_q;
    assign bus.LEDR       = ledr_q;
endmodule
